// File: rtl/display_pkg.sv
// Shared constants, select-bus encodings and capture FSM states for the
// seven-segment display path (scan driver and display_capture monitor).
package display_pkg;

   localparam int NUM_DIGITS = 4;

   localparam logic [7:0] SEL_BLANK  = 8'hFF;
   localparam logic [7:0] SEL_DIGIT0 = 8'hFE;
   localparam logic [7:0] SEL_DIGIT1 = 8'hFD;
   localparam logic [7:0] SEL_DIGIT2 = 8'hFB;
   localparam logic [7:0] SEL_DIGIT3 = 8'hF7;

   localparam logic [NUM_DIGITS-1:0] MASK_EMPTY = '0;
   localparam logic [NUM_DIGITS-1:0] MASK_FULL  = '1;

   typedef enum logic {
      ST_SYNC    = 1'b0,
      ST_COLLECT = 1'b1
   } capture_state_e;

   // One-hot seen-mask bit for a digit index.
   function automatic logic [NUM_DIGITS-1:0] digit_bit(input logic [1:0] idx);
      return {{(NUM_DIGITS-1){1'b0}}, 1'b1} << idx;
   endfunction

endpackage

// File: rtl/digit_select_decoder.sv
// Combinational classifier for the active-low digit-select bus:
// legal single-digit select, blank bus, and the selected digit index.
module digit_select_decoder
   import display_pkg::*;
(
   input  logic [7:0] sel_i,
   output logic       legal_o,
   output logic       blank_o,
   output logic [1:0] index_o
);

   always_comb begin
      // NOTE: every output gets a value before the case so no latch is inferred.
      legal_o = 1'b1;
      index_o = 2'd0;
      blank_o = (sel_i == SEL_BLANK);
      case (sel_i)
         SEL_DIGIT0: index_o = 2'd0;
         SEL_DIGIT1: index_o = 2'd1;
         SEL_DIGIT2: index_o = 2'd2;
         SEL_DIGIT3: index_o = 2'd3;
         default:    legal_o = 1'b0;
      endcase
   end

endmodule

// File: rtl/display_capture.sv
// Rebuilds the 16-bit displayed value from the multiplexed select/nibble bus
// and filters it over STABLE_FRAMES identical frames.
// Optional digit-order checking: define DISPLAY_CAPTURE_ORDER_CHECK_EN.
module display_capture
   import display_pkg::*;
#(
   parameter int STABLE_FRAMES = 2
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [7:0]  digit_select,
   input  logic [3:0]  binary_out,
   output logic [15:0] value,
   output logic        value_valid,
   output logic        frame_done,
   output logic        scan_error
);

   localparam logic [3:0] STABLE_CNT = 4'(STABLE_FRAMES);

   logic       dec_legal;
   logic       dec_blank;
   logic [1:0] dec_index;

   digit_select_decoder u_decoder (
      .sel_i   (digit_select),
      .legal_o (dec_legal),
      .blank_o (dec_blank),
      .index_o (dec_index)
   );

   capture_state_e        state_q, state_d;
   logic [NUM_DIGITS-1:0] mask_q, mask_d;
   logic [15:0]           shadow_q, shadow_d;
   logic [15:0]           prev_q, prev_d;
   logic [3:0]            cnt_q, cnt_d;
   logic [15:0]           value_q, value_d;
   logic                  valid_q, valid_d;
   logic                  frame_done_q, frame_done_d;
   logic                  scan_error_q, scan_error_d;
   logic                  order_ok;

`ifdef DISPLAY_CAPTURE_ORDER_CHECK_EN
   logic [1:0] last_q, last_d;

   // Digit 0 restarts a frame; otherwise stay on or step to the next digit.
   assign order_ok = (dec_index == 2'd0) || (dec_index == last_q) ||
                     (dec_index == last_q + 2'd1);
`else
   assign order_ok = 1'b1;
`endif

   always_comb begin
      state_d      = state_q;
      mask_d       = mask_q;
      shadow_d     = shadow_q;
      prev_d       = prev_q;
      cnt_d        = cnt_q;
      value_d      = value_q;
      valid_d      = valid_q;
      frame_done_d = 1'b0;
      scan_error_d = 1'b0;
`ifdef DISPLAY_CAPTURE_ORDER_CHECK_EN
      last_d       = last_q;
`endif

      if (dec_blank) begin
         // Blank bus between digits carries no information.
      end else if (!dec_legal || (state_q == ST_COLLECT && !order_ok)) begin
         scan_error_d = 1'b1;
         mask_d       = MASK_EMPTY;
         state_d      = ST_SYNC;
      end else if (state_q == ST_SYNC) begin
         if (dec_index == 2'd0) begin
            shadow_d[3:0] = binary_out;
            mask_d        = digit_bit(2'd0);
            state_d       = ST_COLLECT;
`ifdef DISPLAY_CAPTURE_ORDER_CHECK_EN
            last_d        = 2'd0;
`endif
         end
      end else begin
         shadow_d[{dec_index, 2'b00} +: 4] = binary_out;
         mask_d = (dec_index == 2'd0) ? digit_bit(2'd0) : (mask_q | digit_bit(dec_index));
`ifdef DISPLAY_CAPTURE_ORDER_CHECK_EN
         last_d = dec_index;
`endif
         if (mask_d == MASK_FULL) begin
            frame_done_d = 1'b1;
            prev_d       = shadow_d;
            mask_d       = MASK_EMPTY;
            state_d      = ST_SYNC;
            if (shadow_d == prev_q) begin
               cnt_d = (cnt_q >= STABLE_CNT) ? STABLE_CNT : cnt_q + 4'd1;
            end else begin
               cnt_d = 4'd1;
            end
            if (cnt_d == STABLE_CNT) begin
               value_d = shadow_d;
               valid_d = 1'b1;
            end
         end
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values of the others.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q      <= ST_SYNC;
         mask_q       <= MASK_EMPTY;
         shadow_q     <= 16'h0000;
         prev_q       <= 16'h0000;
         cnt_q        <= 4'd0;
         value_q      <= 16'h0000;
         valid_q      <= 1'b0;
         frame_done_q <= 1'b0;
         scan_error_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         mask_q       <= mask_d;
         shadow_q     <= shadow_d;
         prev_q       <= prev_d;
         cnt_q        <= cnt_d;
         value_q      <= value_d;
         valid_q      <= valid_d;
         frame_done_q <= frame_done_d;
         scan_error_q <= scan_error_d;
      end
   end

`ifdef DISPLAY_CAPTURE_ORDER_CHECK_EN
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         last_q <= 2'd0;
      end else begin
         last_q <= last_d;
      end
   end
`endif

   assign value       = value_q;
   assign value_valid = valid_q;
   assign frame_done  = frame_done_q;
   assign scan_error  = scan_error_q;

endmodule

// File: tb/tb_display_capture.sv
// Directed bench for display_capture: a frame-level reference model checked
// every cycle, plus literal expectations at the interesting points.
module tb_display_capture;

   localparam int STABLE = 2;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic [7:0]  sel   = 8'hFF;
   logic [3:0]  nib   = 4'h0;
   logic [15:0] dut_value;
   logic        dut_valid;
   logic        dut_done;
   logic        dut_err;

   int checks   = 0;
   int failures = 0;
   int obs_done = 0;
   int obs_err  = 0;
   bit cmp_en   = 1'b0;

   display_capture #(.STABLE_FRAMES(STABLE)) dut (
      .clock        (clock),
      .reset        (reset),
      .digit_select (digit_sel_bus(sel)),
      .binary_out   (nib),
      .value        (dut_value),
      .value_valid  (dut_valid),
      .frame_done   (dut_done),
      .scan_error   (dut_err)
   );

   function automatic logic [7:0] digit_sel_bus(input logic [7:0] s);
      return s;
   endfunction

   always #5 clock = ~clock;

   // Reference model: what the display path has shown, frame by frame.
   bit          m_collecting;
   bit [3:0]    m_nib [4];
   bit          m_got [4];
   int          m_last;
   bit [15:0]   m_prev;
   int          m_cnt;
   bit [15:0]   m_value;
   bit          m_valid;
   bit          m_done;
   bit          m_err;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int digit_of(input logic [7:0] s);
      case (s)
         8'hFE:   return 0;
         8'hFD:   return 1;
         8'hFB:   return 2;
         8'hF7:   return 3;
         default: return -1;
      endcase
   endfunction

   function automatic logic [7:0] sel_of(input int d);
      logic [7:0] ones;
      ones = 8'hFF;
      return ones ^ (8'd1 << d);
   endfunction

   task automatic model_reset();
      m_collecting = 1'b0;
      foreach (m_got[i]) begin m_got[i] = 1'b0; m_nib[i] = 4'h0; end
      m_last = 0; m_prev = 16'h0; m_cnt = 0;
      m_value = 16'h0; m_valid = 1'b0; m_done = 1'b0; m_err = 1'b0;
   endtask

   task automatic model_start(input logic [3:0] n);
      foreach (m_got[i]) m_got[i] = 1'b0;
      m_nib[0] = n; m_got[0] = 1'b1; m_last = 0; m_collecting = 1'b1;
   endtask

   task automatic model_sample(input logic [7:0] s, input logic [3:0] n);
      int        d;
      bit        all;
      bit [15:0] frame;
      m_done = 1'b0;
      m_err  = 1'b0;
      if (s == 8'hFF) return;
      d = digit_of(s);
      if (d < 0) begin
         m_err = 1'b1; m_collecting = 1'b0;
         return;
      end
      if (!m_collecting) begin
         if (d == 0) model_start(n);
         return;
      end
`ifdef DISPLAY_CAPTURE_ORDER_CHECK_EN
      if (d != 0 && d != m_last && d != m_last + 1) begin
         m_err = 1'b1; m_collecting = 1'b0;
         return;
      end
`endif
      if (d == 0) begin
         model_start(n);
         return;
      end
      m_nib[d] = n; m_got[d] = 1'b1; m_last = d;
      all = m_got[0] && m_got[1] && m_got[2] && m_got[3];
      if (all) begin
         frame = {m_nib[3], m_nib[2], m_nib[1], m_nib[0]};
         m_done = 1'b1;
         m_cnt  = (frame == m_prev) ? ((m_cnt < STABLE) ? m_cnt + 1 : STABLE) : 1;
         m_prev = frame;
         if (m_cnt == STABLE) begin m_value = frame; m_valid = 1'b1; end
         m_collecting = 1'b0;
      end
   endtask

   // Single compare process: outputs registered from the previous sample.
   always @(negedge clock) begin
      if (cmp_en) begin
         check("value", dut_value, m_value);
         check("value_valid", dut_valid, m_valid);
         check("frame_done", dut_done, m_done);
         check("scan_error", dut_err, m_err);
         if (dut_done === 1'b1) obs_done++;
         if (dut_err === 1'b1) obs_err++;
      end
   end

   task automatic step(input logic [7:0] s, input logic [3:0] n);
      @(negedge clock);
      #1;
      sel = s;
      nib = n;
      model_sample(s, n);
   endtask

   task automatic send_frame(input logic [15:0] v, input bit blanks);
      for (int d = 0; d < 4; d++) begin
         step(sel_of(d), v[4*d +: 4]);
         if (blanks) step(8'hFF, 4'h0);
      end
      step(8'hFF, 4'h0);
   endtask

   // Restart with digit 0 mid-frame and overwrite digit 1: shows 16'hBA78.
   task automatic send_messy();
      step(8'hFE, 4'h5); step(8'hFD, 4'h6); step(8'hFE, 4'h8);
      step(8'hFD, 4'h6); step(8'hFD, 4'h7); step(8'hFB, 4'hA);
      step(8'hF7, 4'hB); step(8'hFF, 4'h0);
   endtask

   task automatic do_reset();
      @(negedge clock);
      #1;
      reset = 1'b1; sel = 8'hFF; nib = 4'h0;
      model_reset();
      @(negedge clock);
      @(negedge clock);
      #1;
      reset = 1'b0;
   endtask

   int d0, e0;

   initial begin
      model_reset();
      #1 reset = 1'b1;
      #1;
      check("rst_value", dut_value, 16'h0000);
      check("rst_valid", dut_valid, 1'b0);
      check("rst_done", dut_done, 1'b0);
      check("rst_err", dut_err, 1'b0);
      @(negedge clock);
      @(negedge clock);
      #1 reset = 1'b0;
      cmp_en = 1'b1;

      // Four identical BEEF frames.
      send_frame(16'hBEEF, 1'b0);
      check("beef1_done", dut_done, 1'b1);
      check("beef1_valid", dut_valid, 1'b0);
      send_frame(16'hBEEF, 1'b0);
      check("beef2_value", dut_value, 16'hBEEF);
      check("beef2_valid", dut_valid, 1'b1);
      send_frame(16'hBEEF, 1'b0);
      send_frame(16'hBEEF, 1'b0);
      check("beef_frames", obs_done, 4);
      check("beef_errors", obs_err, 0);

      // 1234, 1235, 1235 from reset.
      do_reset();
      send_frame(16'h1234, 1'b0);
      check("f1234_value", dut_value, 16'h0000);
      check("f1234_valid", dut_valid, 1'b0);
      send_frame(16'h1235, 1'b0);
      check("f1235a_value", dut_value, 16'h0000);
      send_frame(16'h1235, 1'b0);
      check("f1235b_value", dut_value, 16'h1235);
      check("f1235b_valid", dut_valid, 1'b1);

      // Illegal select mid-frame, stray digits then a clean frame.
      d0 = obs_done;
      step(8'hFE, 4'h1); step(8'hFD, 4'h2); step(8'hFC, 4'h0);
      step(8'hFF, 4'h0);
      check("illegal_err", dut_err, 1'b1);
      step(8'hFF, 4'h0);
      check("illegal_err_pulse", dut_err, 1'b0);
      step(8'hFB, 4'h3); step(8'hF7, 4'h4); step(8'hFF, 4'h0);
      check("illegal_no_frame", obs_done, d0);
      send_frame(16'h1235, 1'b0);
      check("recover_done", dut_done, 1'b1);
      check("recover_value", dut_value, 16'h1235);

      // Restart/overwrite; first one is a mismatch while saturated.
      send_messy();
      check("messy1_done", dut_done, 1'b1);
      check("messy1_value_held", dut_value, 16'h1235);
      send_messy();
      check("messy2_value", dut_value, 16'hBA78);

      // Blanks interleaved between every digit.
      d0 = obs_done;
      send_frame(16'hA5A5, 1'b1);
      check("blank_one_frame", obs_done, d0 + 1);
      check("blank1_value_held", dut_value, 16'hBA78);
      send_frame(16'hA5A5, 1'b1);
      check("blank2_value", dut_value, 16'hA5A5);

      // Asynchronous reset after digits 0,1.
      step(8'hFE, 4'h3); step(8'hFD, 4'h4);
      #2 reset = 1'b1;
      sel = 8'hFF;
      model_reset();
      #1;
      check("midrst_value", dut_value, 16'h0000);
      check("midrst_valid", dut_valid, 1'b0);
      @(negedge clock);
      #1 reset = 1'b0;
      d0 = obs_done;
      step(8'hFB, 4'h5); step(8'hF7, 4'h6); step(8'hFF, 4'h0);
      check("midrst_ignored", obs_done, d0);
      send_frame(16'h0000, 1'b0);
      check("zero1_done", dut_done, 1'b1);
      check("zero1_valid", dut_valid, 1'b0);
      send_frame(16'h0000, 1'b0);
      check("zero2_valid", dut_valid, 1'b1);
      check("zero2_value", dut_value, 16'h0000);

      // Out-of-order scan 0,2,1,3.
      d0 = obs_done;
      e0 = obs_err;
      step(8'hFE, 4'h1); step(8'hFB, 4'h2); step(8'hFD, 4'h3);
      step(8'hF7, 4'h4); step(8'hFF, 4'h0); step(8'hFF, 4'h0);
`ifdef DISPLAY_CAPTURE_ORDER_CHECK_EN
      check("order_no_frame", obs_done, d0);
      check("order_error", obs_err, e0 + 1);
`else
      check("order_frame", obs_done, d0 + 1);
      check("order_no_error", obs_err, e0);
`endif
      check("order_value_held", dut_value, 16'h0000);

      cmp_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/display_capture.md
# display_capture

Receive-side counterpart of the seven-segment scan multiplexer. Samples the multiplexed digit-select / nibble bus, rebuilds the 16-bit displayed value, and filters it over consecutive scan frames. Used as a loopback monitor on the display path and as the reference model in display-path benches.

## Interface
- STABLE_FRAMES, 2: identical consecutive complete frames required before `value` updates (1..15)
- clock  in  1  system clock; all sampling on rising edge
- reset  in  1  asynchronous, active-high
- digit_select  in  8  scan select bus, active-low one-hot on [3:0], [7:4] held high
- binary_out  in  4  nibble for the currently selected digit
- value  out  16  filtered reconstructed value; digit n in [4n+3:4n]
- value_valid  out  1  high once `value` holds a filtered frame; sticky until reset
- frame_done  out  1  one-cycle pulse per completed frame
- scan_error  out  1  one-cycle pulse per illegal or out-of-sequence sample

## Operation
- Legal sample: [7:4]=4'hF and exactly one of [3:0] low; digit index = position of the low bit.
- Blank sample: 8'hFF; ignored, no state change.
- Illegal sample: any other pattern; pulse `scan_error`, clear seen-mask, go to SYNC.
- FSM, 2 states:
  - SYNC: ignore legal digits 1..3. Digit 0 writes shadow[0], sets seen-mask=4'b0001, goes to COLLECT.
  - COLLECT: legal digit n writes shadow[n] and sets mask bit n. Digit 0 restarts the frame (mask=4'b0001). A repeated digit overwrites its shadow slot.
- Frame complete: mask reaches 4'hF. Then:
  - pulse `frame_done`;
  - compare shadow to prev_frame, then load prev_frame from shadow;
  - go to SYNC.
- Stability counter (4 bits, saturating at STABLE_FRAMES):
  - frame equal to prev_frame: increment;
  - frame differs: load 1.
  - On reaching STABLE_FRAMES: `value` ← shadow and `value_valid` ← 1.
  - While saturated, every further matching frame rewrites `value` with the same data.
- First frame after reset compares against prev_frame=16'h0000. It counts as a match only if the frame data is 0.

## Timing
- Inputs are registered by the driver; no synchronizer on this block.
- Sample edge k holding the final digit produces `frame_done`, plus any `value`/`value_valid` update, registered at edge k+1.
- `scan_error` is asserted for the cycle after the offending sample.
- With a 4-cycle driver scan: one frame every 4 samples. With STABLE_FRAMES=2, `value` is valid 1 cycle after the last digit of the second identical frame.
- Reset values: value=16'h0000, value_valid=0, frame_done=0, scan_error=0, state=SYNC, mask=0, prev_frame=0, stability count=0.
- Reset asserted mid-frame discards partial shadow immediately (asynchronous). The first post-reset digit 0 starts a fresh frame.
- Simultaneous frame completion and mismatch: the count loads 1, `value` is held, `frame_done` still pulses.

## Configuration
- Macro: DISPLAY_CAPTURE_ORDER_CHECK_EN.
- Defined: in COLLECT, a legal digit must equal the previous digit or the previous digit + 1; digit 0 is always accepted. Any other digit pulses `scan_error` and returns to SYNC.
- Undefined: digits in COLLECT are accepted in any order. Completion is purely by mask.

## Structure
- Shared package `display_pkg`:
  - NUM_DIGITS=4;
  - SEL_BLANK=8'hFF;
  - per-digit select constants 8'hFE/FD/FB/F7;
  - FSM state encoding SYNC/COLLECT.
- Sub-module `digit_select_decoder`: combinational. Maps the 8-bit select bus to {legal, blank, index[1:0]}, and is reusable by the driver's assertions.

## Test plan
- Drive four frames of 16'hBEEF in scan order 0,1,2,3, STABLE_FRAMES=2 -> `frame_done` after each frame; `value`=16'hBEEF and `value_valid`=1 after frame 2; no `scan_error`.
- Frames 16'h1234, 16'h1235, 16'h1235 -> `value` stays 0 until frame 3, then 16'h1235; count reloads to 1 at frame 2.
- Sample 8'hFC mid-frame -> `scan_error` for one cycle, no `frame_done` for that frame; next full frame completes normally.
- Blank samples 8'hFF interleaved between every digit of 16'hA5A5 -> still one `frame_done`, data intact.
- Assert reset after digits 0,1 of a frame -> all outputs 0 immediately; digits 2,3 that follow are ignored until digit 0.
- With DISPLAY_CAPTURE_ORDER_CHECK_EN, order 0,2,1,3 -> `scan_error` on digit 2 and no frame. Without the macro, the same order -> `frame_done`.
